el2_bp_hash_ghr_pipe: RTL and testbench
=======================================

Name: el2_bp_hash_ghr_pipe

Overview:
- Next-generation branch-predictor hashing block with state.
- Computes the BTB/BHT index hash and the BTB tag hash from the fetch PC, using a parametrised fold count for each.
- Owns the speculative and committed global history registers (GHR) and returns a registered result with the GHR snapshot, so execute can repair history on a mispredict.
- Sits between the IFU fetch-address stage and the BTB/BHT array read ports.

Parameters:
- ADDR_LO, 2, LSB of the PC index field.
- ADDR_W, 8, index width. Index field k is pc[ADDR_LO+k*ADDR_W +: ADDR_W].
- NUM_FOLDS, 3, number of index fields XORed together (legal 1..3).
- TAG_W, 5, tag hash width.
- TAG_FOLDS, 2, number of tag fields XORed together (legal 1..3). Tag field k is pc[ADDR_LO+ADDR_W+k*TAG_W +: TAG_W].
- GHR_SIZE, 8, global history length (legal 1..2*ADDR_W).
- Elaboration-time check: ADDR_LO+NUM_FOLDS*ADDR_W ≤ 32 and ADDR_LO+ADDR_W+TAG_FOLDS*TAG_W ≤ 32. Otherwise `$error`.

Ports:
- clk, in, 1, core clock.
- rst, in, 1, asynchronous active-high reset.
- lookup_valid, in, 1, fetch lookup request.
- lookup_pc, in, 31 [31:1], fetch address.
- lookup_stall, in, 1, hold the output stage.
- pred_valid, in, 1, a prediction was made this cycle.
- pred_taken, in, 1, predicted direction.
- commit_valid, in, 1, a branch retired.
- commit_taken, in, 1, retired direction.
- mispred_valid, in, 1, mispredict repair.
- mispred_ghr, in, GHR_SIZE, snapshot carried with the mispredicted branch.
- mispred_taken, in, 1, resolved direction.
- flush_valid, in, 1, non-branch pipeline flush.
- idx_valid, out, 1, output stage valid.
- idx, out, ADDR_W, hashed index (PC fold XOR GHR fold).
- tag, out, TAG_W, hashed tag.
- ghr_snap, out, GHR_SIZE, sghr value used for this lookup.
- sghr_o, out, GHR_SIZE, current speculative GHR.
- cghr_o, out, GHR_SIZE, current committed GHR.

Behaviour:
- Reset:
  - Asynchronous and active-high.
  - idx_valid, idx, tag, ghr_snap, sghr, cghr all go to 0 immediately, including mid-operation.
  - First valid output appears 2 cycles after rst deasserts plus a lookup.
- Hash (combinational on inputs):
  - pc_fold = XOR of NUM_FOLDS index fields.
  - ghr_fold = XOR of ADDR_W-bit chunks of sghr. The last chunk is zero-extended at the MSB end.
  - idx_next = pc_fold ^ ghr_fold.
  - tag_next = XOR of TAG_FOLDS tag fields.
  - lookup_pc bit 0 position corresponds to pc[1]. Bits below ADDR_LO are ignored.
- Latency: 1 cycle. A lookup at cycle N drives idx/tag/ghr_snap at N+1.
- Output register:
  - If lookup_stall=1, all output-stage fields hold, including idx_valid. A lookup presented while stalled is dropped; the requester must re-present it.
  - Else idx_valid <= lookup_valid. idx/tag/ghr_snap load only when lookup_valid=1, otherwise they hold their last value.
  - mispred_valid or flush_valid clears idx_valid next cycle, overriding stall.
- GHR source for hashing: the sghr register value at the start of the cycle. Same-cycle pred/mispred/flush updates are not bypassed; ghr_snap equals that same value.
- Speculative GHR (sghr) next-state, highest priority first:
  1. mispred_valid: sghr <= {mispred_ghr[GHR_SIZE-2:0], mispred_taken}.
  2. flush_valid: sghr <= cghr_next (committed value including this cycle's commit).
  3. pred_valid: sghr <= {sghr[GHR_SIZE-2:0], pred_taken}.
  4. Otherwise hold.
- Committed GHR (cghr): commit_valid gives cghr <= {cghr[GHR_SIZE-2:0], commit_taken}. It is independent of all other inputs.
- GHR_SIZE=1: shift degenerates to sghr <= direction bit.
- Wrap: history shifts out at the MSB silently. There is no overflow indication.
- sghr_o/cghr_o are direct register outputs.

Test Plan:
- Reset then lookup pc=0x0000_0404, defaults, sghr=0 -> next cycle idx_valid=1, idx=0x00, tag=0x01, ghr_snap=0x00.
- 3× pred_valid taken=1, then lookup pc=0x0000_0404 -> sghr=0x07, idx=0x07, ghr_snap=0x07. Also: lookup in the same cycle as a pred -> snapshot shows the pre-update value.
- With sghr=0x07: mispred_valid, mispred_ghr=0x05, mispred_taken=0, pred_valid=1 in the same cycle -> sghr=0x0A (mispred wins), idx_valid=0 next cycle.
- From reset: 2× commit taken=1, several preds taken=0, then flush_valid with commit_valid taken=1 in the same cycle -> cghr=0x07, sghr=0x07.
- lookup_stall=1 for 3 cycles after a valid result -> idx/tag/idx_valid unchanged. Then mispred_valid during stall -> idx_valid=0.
- Assert rst asynchronously mid-cycle while idx_valid=1 and sghr=0xA5 -> all outputs 0 before the next clk edge. NUM_FOLDS=1 build: pc=0x0000_0404 gives idx=0x01.

Source files
------------

// File: rtl/el2_bp_hash_ghr_pipe.sv
// Branch-predictor index/tag hash with speculative and committed GHR.
// One-cycle registered lookup result carries the GHR snapshot for repair.
module el2_bp_hash_ghr_pipe #(
  parameter int ADDR_LO   = 2,
  parameter int ADDR_W    = 8,
  parameter int NUM_FOLDS = 3,
  parameter int TAG_W     = 5,
  parameter int TAG_FOLDS = 2,
  parameter int GHR_SIZE  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_valid,
  input  logic [31:1]         lookup_pc,
  input  logic                lookup_stall,
  input  logic                pred_valid,
  input  logic                pred_taken,
  input  logic                commit_valid,
  input  logic                commit_taken,
  input  logic                mispred_valid,
  input  logic [GHR_SIZE-1:0] mispred_ghr,
  input  logic                mispred_taken,
  input  logic                flush_valid,
  output logic                idx_valid,
  output logic [ADDR_W-1:0]   idx,
  output logic [TAG_W-1:0]    tag,
  output logic [GHR_SIZE-1:0] ghr_snap,
  output logic [GHR_SIZE-1:0] sghr_o,
  output logic [GHR_SIZE-1:0] cghr_o
);

  if (ADDR_LO + NUM_FOLDS*ADDR_W > 32 ||
      ADDR_LO + ADDR_W + TAG_FOLDS*TAG_W > 32) begin : g_chk
    $error("el2_bp_hash_ghr_pipe: fold fields exceed PC width");
  end

  logic [31:0]         pc;
  logic [ADDR_W-1:0]   pc_fold;
  logic [ADDR_W-1:0]   ghr_fold;
  logic [2*ADDR_W-1:0] ghr_ext;
  logic [TAG_W-1:0]    tag_d;
  logic [ADDR_W-1:0]   idx_d;

  logic                vld_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [TAG_W-1:0]    tag_q;
  logic [GHR_SIZE-1:0] snap_q;
  logic [GHR_SIZE-1:0] sghr_q, sghr_d;
  logic [GHR_SIZE-1:0] cghr_q, cghr_d;

  // Shift one direction bit in at the LSB; works for GHR_SIZE == 1.
  function automatic logic [GHR_SIZE-1:0] shl(
    input logic [GHR_SIZE-1:0] h,
    input logic                b
  );
    logic [GHR_SIZE:0] t;
    t = {h, b};
    return t[GHR_SIZE-1:0];
  endfunction

  assign pc = {lookup_pc, 1'b0};

  always_comb begin
    pc_fold = '0;
    for (int k = 0; k < NUM_FOLDS; k++)
      pc_fold = pc_fold ^ pc[ADDR_LO+k*ADDR_W +: ADDR_W];
    tag_d = '0;
    for (int k = 0; k < TAG_FOLDS; k++)
      tag_d = tag_d ^ pc[ADDR_LO+ADDR_W+k*TAG_W +: TAG_W];
  end

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_SIZE-1:0] = sghr_q;
  end

  assign ghr_fold = ghr_ext[ADDR_W-1:0] ^ ghr_ext[2*ADDR_W-1:ADDR_W];
  assign idx_d    = pc_fold ^ ghr_fold;

  always_comb begin
    cghr_d = cghr_q;
    if (commit_valid)
      cghr_d = shl(cghr_q, commit_taken);
  end

  always_comb begin
    sghr_d = sghr_q;
    if (mispred_valid)
      sghr_d = shl(mispred_ghr, mispred_taken);
    else if (flush_valid)
      sghr_d = cghr_d;
    else if (pred_valid)
      sghr_d = shl(sghr_q, pred_taken);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sghr_q <= '0;
      cghr_q <= '0;
    end else begin
      sghr_q <= sghr_d;
      cghr_q <= cghr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      idx_q  <= '0;
      tag_q  <= '0;
      snap_q <= '0;
    end else begin
      if (mispred_valid || flush_valid)
        vld_q <= 1'b0;
      else if (!lookup_stall)
        vld_q <= lookup_valid;
      if (!lookup_stall && lookup_valid) begin
        idx_q  <= idx_d;
        tag_q  <= tag_d;
        snap_q <= sghr_q;
      end
    end
  end

  assign idx_valid = vld_q;
  assign idx       = idx_q;
  assign tag       = tag_q;
  assign ghr_snap  = snap_q;
  assign sghr_o    = sghr_q;
  assign cghr_o    = cghr_q;

endmodule

// File: tb/tb_el2_bp_hash_ghr_pipe.sv
// Scoreboard bench for el2_bp_hash_ghr_pipe: stimulus queues expected
// lookup results, a negedge monitor pops and compares them.
module tb_el2_bp_hash_ghr_pipe;

  typedef struct packed {
    logic [7:0] idx;
    logic [4:0] tag;
    logic [7:0] snap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid, lookup_stall;
  logic [31:1] lookup_pc;
  logic        pred_valid, pred_taken;
  logic        commit_valid, commit_taken;
  logic        mispred_valid, mispred_taken;
  logic [7:0]  mispred_ghr;
  logic        flush_valid;

  logic        idx_valid;
  logic [7:0]  idx;
  logic [4:0]  tag;
  logic [7:0]  ghr_snap, sghr_o, cghr_o;

  logic        u1_valid;
  logic [7:0]  u1_idx;
  logic [4:0]  u1_tag;
  logic [7:0]  u1_snap, u1_sghr, u1_cghr;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  exp_t last;
  logic stall_q = 1'b0;

  always #5 clk = ~clk;

  el2_bp_hash_ghr_pipe dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .lookup_stall(lookup_stall),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .commit_valid(commit_valid), .commit_taken(commit_taken),
    .mispred_valid(mispred_valid), .mispred_ghr(mispred_ghr),
    .mispred_taken(mispred_taken), .flush_valid(flush_valid),
    .idx_valid(idx_valid), .idx(idx), .tag(tag),
    .ghr_snap(ghr_snap), .sghr_o(sghr_o), .cghr_o(cghr_o)
  );

  el2_bp_hash_ghr_pipe #(.NUM_FOLDS(1)) u1 (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .lookup_stall(lookup_stall),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .commit_valid(commit_valid), .commit_taken(commit_taken),
    .mispred_valid(mispred_valid), .mispred_ghr(mispred_ghr),
    .mispred_taken(mispred_taken), .flush_valid(flush_valid),
    .idx_valid(u1_valid), .idx(u1_idx), .tag(u1_tag),
    .ghr_snap(u1_snap), .sghr_o(u1_sghr), .cghr_o(u1_cghr)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    lookup_valid  = 1'b0;
    lookup_pc     = '0;
    lookup_stall  = 1'b0;
    pred_valid    = 1'b0;
    pred_taken    = 1'b0;
    commit_valid  = 1'b0;
    commit_taken  = 1'b0;
    mispred_valid = 1'b0;
    mispred_ghr   = '0;
    mispred_taken = 1'b0;
    flush_valid   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc, input exp_t e);
    lookup_valid = 1'b1;
    lookup_pc    = pc[31:1];
    q.push_back(e);
  endtask

  always @(posedge clk) stall_q <= lookup_stall;

  // Fresh result when the previous edge was not stalled, else a hold.
  always @(negedge clk) begin
    if (!rst && idx_valid) begin
      if (!stall_q) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          last = q.pop_front();
          chk("idx",  {24'd0, idx},      {24'd0, last.idx});
          chk("tag",  {27'd0, tag},      {27'd0, last.tag});
          chk("snap", {24'd0, ghr_snap}, {24'd0, last.snap});
        end
      end else begin
        chk("hold_idx", {24'd0, idx}, {24'd0, last.idx});
        chk("hold_tag", {27'd0, tag}, {27'd0, last.tag});
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    #12;
    chk("rst_valid", {31'd0, idx_valid}, 32'd0);
    chk("rst_sghr",  {24'd0, sghr_o},    32'd0);
    chk("rst_cghr",  {24'd0, cghr_o},    32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Basic hash with empty history.
    lookup(32'h0000_0404, '{idx: 8'h00, tag: 5'h01, snap: 8'h00});
    tick();
    idle();
    chk("u1_idx_onefold", {24'd0, u1_idx}, 32'h01);

    // Three taken predictions fill history.
    pred_valid = 1'b1;
    pred_taken = 1'b1;
    repeat (3) tick();
    idle();
    chk("sghr_3taken", {24'd0, sghr_o}, 32'h07);
    lookup(32'h0000_0404, '{idx: 8'h07, tag: 5'h01, snap: 8'h07});
    tick();
    // Same-cycle pred is not bypassed into the hash.
    lookup(32'h0000_0404, '{idx: 8'h07, tag: 5'h01, snap: 8'h07});
    pred_valid = 1'b1;
    pred_taken = 1'b0;
    tick();
    idle();
    chk("sghr_after_pred", {24'd0, sghr_o}, 32'h0E);

    // Mispredict beats prediction and kills output valid.
    mispred_valid = 1'b1;
    mispred_ghr   = 8'h05;
    mispred_taken = 1'b0;
    pred_valid    = 1'b1;
    pred_taken    = 1'b1;
    tick();
    idle();
    chk("sghr_mispred", {24'd0, sghr_o}, 32'h0A);
    chk("valid_mispred", {31'd0, idx_valid}, 32'd0);

    // Stall holds the output; a stalled lookup is dropped.
    lookup(32'h0000_0C08, '{idx: 8'h0B, tag: 5'h03, snap: 8'h0A});
    tick();
    idle();
    lookup_stall = 1'b1;
    lookup_valid = 1'b1;
    lookup_pc    = 31'h202;
    repeat (3) tick();
    chk("stall_valid", {31'd0, idx_valid}, 32'd1);
    chk("stall_idx",   {24'd0, idx},       32'h0B);
    mispred_valid = 1'b1;
    mispred_ghr   = 8'h52;
    mispred_taken = 1'b1;
    tick();
    idle();
    chk("stall_mispred_valid", {31'd0, idx_valid}, 32'd0);
    chk("sghr_a5", {24'd0, sghr_o}, 32'hA5);

    // Flush restores sghr from committed history incl. same-cycle commit.
    commit_valid = 1'b1;
    commit_taken = 1'b1;
    repeat (2) tick();
    idle();
    chk("cghr_2commit", {24'd0, cghr_o}, 32'h03);
    pred_valid = 1'b1;
    repeat (2) tick();
    idle();
    chk("sghr_preds0", {24'd0, sghr_o}, 32'h94);
    flush_valid  = 1'b1;
    commit_valid = 1'b1;
    commit_taken = 1'b1;
    tick();
    idle();
    chk("cghr_flush", {24'd0, cghr_o}, 32'h07);
    chk("sghr_flush", {24'd0, sghr_o}, 32'h07);

    // Async reset mid-cycle with live output and non-zero history.
    mispred_valid = 1'b1;
    mispred_ghr   = 8'h52;
    mispred_taken = 1'b1;
    tick();
    idle();
    lookup(32'h0000_0404, '{idx: 8'hA5, tag: 5'h01, snap: 8'hA5});
    tick();
    idle();
    chk("pre_rst_valid", {31'd0, idx_valid}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, idx_valid}, 32'd0);
    chk("arst_idx",   {24'd0, idx},       32'd0);
    chk("arst_tag",   {27'd0, tag},       32'd0);
    chk("arst_snap",  {24'd0, ghr_snap},  32'd0);
    chk("arst_sghr",  {24'd0, sghr_o},    32'd0);
    chk("arst_cghr",  {24'd0, cghr_o},    32'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
